// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC cosine iterator.
// Contents: width/iteration defaults, the CORDIC gain K, the arctangent table, the IEEE-754
// single field sizes and bias, the controller state type, and the combinational
// float<->fixed conversion functions.
// Fixed-point values are two's complement with `width` fractional bits, carried in 64-bit
// containers so that every function works for any legal width.
package cordic_pkg;

  localparam int unsigned DefaultWidth      = 24;
  localparam int unsigned DefaultIterations = 24;
  localparam int unsigned MaxStages         = 32;

  localparam int unsigned ExpBits  = 8;
  localparam int unsigned MantBits = 23;
  localparam int          ExpBias  = 127;

  // 0.6072529 * 2^24, the reciprocal of the accumulated CORDIC gain.
  localparam logic [31:0] KQ24 = 32'h009B_74EE;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StConv
  } state_e;

  // round(atan(2^-i) * 2^24). For i >= 8 the cubic term is below half an LSB, so the
  // entry is exactly 2^(24-i); beyond i = 24 it rounds to zero.
  function automatic logic [31:0] atan_q24(input logic [4:0] i);
    logic [31:0] v;
    case (i)
      5'd0:    v = 32'h00C9_0FDB;
      5'd1:    v = 32'h0076_B19C;
      5'd2:    v = 32'h003E_B6EC;
      5'd3:    v = 32'h001F_D5BB;
      5'd4:    v = 32'h000F_FAAE;
      5'd5:    v = 32'h0007_FF55;
      5'd6:    v = 32'h0003_FFEB;
      5'd7:    v = 32'h0001_FFFD;
      default: v = (i <= 5'd24) ? (32'd1 << (5'd24 - i)) : 32'd0;
    endcase
    return v;
  endfunction

  // Rescale a value with 24 fractional bits to `width` fractional bits (rounding when
  // narrowing).
  function automatic logic [63:0] scale_q24(input logic [31:0] v, input int unsigned width);
    logic [63:0] r;
    if (width >= 24) begin
      r = 64'(v) << (width - 24);
    end else begin
      r = (64'(v) + (64'd1 << (23 - width))) >> (24 - width);
    end
    return r;
  endfunction

  // IEEE-754 single to fixed point, truncating toward zero. Zeros and denormals give 0;
  // magnitudes above 1.0, infinities and NaNs saturate to +/-2^width (NaN always positive).
  function automatic logic [63:0] float_to_fixed(input logic [31:0] f, input int unsigned width);
    logic                sgn;
    logic [ExpBits-1:0]  ex;
    logic [MantBits-1:0] man;
    logic                nan;
    logic [63:0]         mag;
    int                  sh;
    sgn = f[31];
    ex  = f[30:23];
    man = f[22:0];
    nan = (ex == '1) && (man != '0);
    sh  = int'(ex) - ExpBias - int'(MantBits) + int'(width);
    mag = '0;
    if (ex == '0) begin
      mag = '0;
    end else if (f[30:0] > 31'h3F80_0000) begin
      mag = 64'd1 << width;
    end else if (sh >= 0) begin
      mag = 64'({1'b1, man}) << sh;
    end else if (sh > -64) begin
      mag = 64'({1'b1, man}) >> (-sh);
    end
    // Negating the magnitude after the shift keeps truncation toward zero.
    return (sgn && !nan) ? -mag : mag;
  endfunction

  // Fixed point (sign-extended to 64 bits) to IEEE-754 single, mantissa truncated.
  function automatic logic [31:0] fixed_to_float(input logic signed [63:0] x,
                                                 input int unsigned width);
    logic               sgn;
    logic [63:0]        mag;
    logic [63:0]        norm;
    logic [ExpBits-1:0] ex;
    logic [31:0]        r;
    int                 p;
    sgn = x[63];
    mag = sgn ? -x : x;
    p   = 0;
    for (int b = 0; b < 64; b++) begin
      if (mag[b]) p = b;
    end
    // Leading one moves to bit 63; the 23 bits below it are the mantissa.
    norm = mag << (63 - p);
    ex   = ExpBits'(ExpBias + p - int'(width));
    r    = {sgn, ex, MantBits'(norm >> 40)};
    if (mag == '0) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation in rotation mode.
// Ports:
//   x_i, y_i, z_i : pre-iteration vector and residual angle
//   shift_i       : iteration index i, used as the arithmetic shift amount
//   atan_i        : atan(2^-i) in the same fixed-point format
//   x_o, y_o, z_o : post-iteration values (two's-complement wrap in W bits)
module cordic_stage #(
  parameter int unsigned W = 26
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] z_i,
  input  logic        [4:0]   shift_i,
  input  logic signed [W-1:0] atan_i,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic signed [W-1:0] z_o
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  always_comb begin
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    // Rotate toward zero residual: positive z rotates by +atan, negative by -atan.
    if (!z_i[W-1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cosine_iterator.sv
// Iterative CORDIC cosine: accepts an IEEE-754 single angle in radians and returns cos(angle)
// as an IEEE-754 single after ITERATIONS+2 cycles.
// Ports:
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   in_valid/ready  : request handshake; ready is high only while idle
//   angle           : input angle, IEEE-754 single
//   out_valid       : one-cycle pulse when result is updated
//   result          : cos(angle), IEEE-754 single, held until the next pulse
//   theta           : accepted angle in fixed point (WIDTH fractional bits)
//   x_s, w_s        : per-iteration x and residual z; entry 0 is the initial state,
//                     entries above ITERATIONS read 0, all held until the next accept
module cosine_iterator
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned ITERATIONS = DefaultIterations
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       angle,
  output logic                              out_valid,
  output logic [31:0]                       result,
  output logic [WIDTH+1:0]                  theta,
  output logic [MaxStages-1:0][WIDTH+1:0]   x_s,
  output logic [MaxStages-1:0][WIDTH+1:0]   w_s
);

  localparam int unsigned         W2       = WIDTH + 2;
  localparam logic [4:0]          LastIter = 5'(ITERATIONS - 1);
  localparam logic signed [W2-1:0] KInit   = W2'(scale_q24(KQ24, WIDTH));

  state_e                          state_q;
  logic [4:0]                      cnt_q;
  logic signed [W2-1:0]            x_q;
  logic signed [W2-1:0]            y_q;
  logic signed [W2-1:0]            z_q;
  logic signed [W2-1:0]            theta_q;
  logic [31:0]                     result_q;
  logic                            out_valid_q;
  logic                            in_ready_q;
  logic [MaxStages-1:0][W2-1:0]    xs_q;
  logic [MaxStages-1:0][W2-1:0]    ws_q;

  logic signed [W2-1:0]            theta_in;
  logic signed [W2-1:0]            atan_cur;
  logic signed [W2-1:0]            x_nxt;
  logic signed [W2-1:0]            y_nxt;
  logic signed [W2-1:0]            z_nxt;
  logic [31:0]                     result_in;

  assign theta_in  = W2'(float_to_fixed(angle, WIDTH));
  assign atan_cur  = W2'(scale_q24(atan_q24(cnt_q), WIDTH));
  assign result_in = fixed_to_float(64'(x_q), WIDTH);

  cordic_stage #(
    .W (W2)
  ) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .atan_i  (atan_cur),
    .x_o     (x_nxt),
    .y_o     (y_nxt),
    .z_o     (z_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      theta_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      xs_q        <= '0;
      ws_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            theta_q    <= theta_in;
            x_q        <= KInit;
            y_q        <= '0;
            z_q        <= theta_in;
            cnt_q      <= '0;
            xs_q       <= '0;
            ws_q       <= '0;
            xs_q[0]    <= KInit;
            ws_q[0]    <= theta_in;
            in_ready_q <= 1'b0;
            state_q    <= StIter;
          end
        end
        StIter: begin
          x_q                   <= x_nxt;
          y_q                   <= y_nxt;
          z_q                   <= z_nxt;
          xs_q[cnt_q + 5'd1]    <= x_nxt;
          ws_q[cnt_q + 5'd1]    <= z_nxt;
          if (cnt_q == LastIter) begin
            state_q <= StConv;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StConv: begin
          result_q    <= result_in;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign theta     = theta_q;
  assign x_s       = xs_q;
  assign w_s       = ws_q;

endmodule

// File: tb/tb_cosine_iterator.sv
// Directed self-checking bench for cosine_iterator (WIDTH=24, ITERATIONS=24).
module tb_cosine_iterator;

  localparam logic [31:0] KVal = 32'h009B_74EE;
  localparam int          Lat  = 26;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        angle;
  logic               out_valid;
  logic [31:0]        result;
  logic [25:0]        theta;
  logic [31:0][25:0]  x_s;
  logic [31:0][25:0]  w_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cosine_iterator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .out_valid (out_valid),
    .result    (result),
    .theta     (theta),
    .x_s       (x_s),
    .w_s       (w_s)
  );

  // Compares as unsigned integers; for same-sign floats the distance is in ulp.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want,
                     input int unsigned tol);
    longint d;
    n_cmp++;
    d = longint'(got) - longint'(want);
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (tol %0d)", tag, got, want, tol);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_req(input logic [31:0] a, output int lat);
    @(negedge clk);
    chk("acc_rdy", 32'(in_ready), 32'd1, 0);
    angle    = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat);
  endtask

  task automatic theta_case(input string tag, input logic [31:0] a, input logic [31:0] th);
    int lat;
    run_req(a, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(Lat), 0);
    chk({tag, "_theta"}, 32'(theta), th, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1, 0);
    chk({tag, "_ovld"}, 32'(out_valid), 32'd0, 0);
    chk({tag, "_res"}, result, 32'd0, 0);
    chk({tag, "_theta"}, 32'(theta), 32'd0, 0);
    chk({tag, "_xs"}, 32'(|x_s), 32'd0, 0);
    chk({tag, "_ws"}, 32'(|w_s), 32'd0, 0);
  endtask

  initial begin
    int lat;
    int gap;
    int pulses;

    rst      = 1'b0;
    in_valid = 1'b0;
    angle    = '0;
    #1 rst = 1'b1;
    #1 chk_reset_state("rst0");
    #20;
    @(negedge clk) rst = 1'b0;

    // cos(0): first two micro-rotations worked by hand.
    run_req(32'h0000_0000, lat);
    chk("a0_lat", 32'(lat), 32'(Lat), 0);
    chk("a0_rdy_at_valid", 32'(in_ready), 32'd1, 0);
    chk("a0_theta", 32'(theta), 32'h0, 0);
    chk("a0_xs0", 32'(x_s[0]), KVal, 0);
    chk("a0_ws0", 32'(w_s[0]), 32'h0, 0);
    chk("a0_xs1", 32'(x_s[1]), KVal, 0);
    chk("a0_ws1", 32'(w_s[1]), 32'h336_F025, 0);
    chk("a0_xs2", 32'(x_s[2]), 32'h0E9_2F65, 0);
    chk("a0_ws2", 32'(w_s[2]), 32'h3AD_A1C1, 0);
    chk("a0_xs25", 32'(x_s[25]), 32'h0, 0);
    chk("a0_ws31", 32'(w_s[31]), 32'h0, 0);
    chk("a0_result", result, 32'h3F80_0000, 16);
    @(negedge clk);
    chk("a0_pulse", 32'(out_valid), 32'd0, 0);
    repeat (3) @(negedge clk);
    chk("a0_hold", result, 32'h3F80_0000, 16);

    // cos(1.0)
    run_req(32'h3F80_0000, lat);
    chk("a1_lat", 32'(lat), 32'(Lat), 0);
    chk("a1_theta", 32'(theta), 32'h100_0000, 0);
    chk("a1_ws1", 32'(w_s[1]), 32'h036_F025, 0);
    chk("a1_result", result, 32'h3F0A_5147, 16);

    // cos(-0.5)
    run_req(32'hBF00_0000, lat);
    chk("am05_lat", 32'(lat), 32'(Lat), 0);
    chk("am05_theta", 32'(theta), 32'h380_0000, 0);
    chk("am05_xs1", 32'(x_s[1]), KVal, 0);
    chk("am05_ws1", 32'(w_s[1]), 32'h049_0FDB, 0);
    chk("am05_result", result, 32'h3F60_A940, 16);

    // cos(2.0) saturates to the 1.0 case
    run_req(32'h4000_0000, lat);
    chk("a2_lat", 32'(lat), 32'(Lat), 0);
    chk("a2_theta", 32'(theta), 32'h100_0000, 0);
    chk("a2_result", result, 32'h3F0A_5147, 16);

    // Conversion boundaries
    theta_case("negzero", 32'h8000_0000, 32'h000_0000);
    theta_case("denorm", 32'h0000_0001, 32'h000_0000);
    theta_case("ndenorm", 32'h807F_FFFF, 32'h000_0000);
    theta_case("q025", 32'h3E80_0000, 32'h040_0000);
    theta_case("q075", 32'h3F40_0000, 32'h0C0_0000);
    theta_case("p01", 32'h3DCC_CCCD, 32'h019_9999);
    theta_case("m01", 32'hBDCC_CCCD, 32'h3E6_6667);
    theta_case("pinf", 32'h7F80_0000, 32'h100_0000);
    theta_case("minf", 32'hFF80_0000, 32'h300_0000);
    theta_case("nan", 32'hFFC0_0000, 32'h100_0000);
    theta_case("m2", 32'hC000_0000, 32'h300_0000);

    // in_valid held through the busy period
    @(negedge clk);
    angle    = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    gap    = -1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (in_ready) begin
        gap = k;
        break;
      end
    end
    chk("b2b_gap", 32'(gap), 32'(Lat), 0);
    chk("b2b_pulses", 32'(pulses), 32'd1, 0);
    chk("b2b_res1", result, 32'h3F0A_5147, 16);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b_rdy_drop", 32'(in_ready), 32'd0, 0);
    wait_done(lat);
    chk("b2b_lat2", 32'(lat), 32'(Lat), 0);
    chk("b2b_res2", result, 32'h3F0A_5147, 16);

    // Reset during iteration 10 of a 1.0 request
    @(negedge clk);
    angle    = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_state("rstmid");
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("rstmid_nopulse", 32'(pulses), 32'd0, 0);
    chk_reset_state("rsthold");
    rst      = 1'b0;
    angle    = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("rstpost_accept", 32'(in_ready), 32'd0, 0);
    wait_done(lat);
    chk("rstpost_lat", 32'(lat), 32'(Lat), 0);
    chk("rstpost_theta", 32'(theta), 32'h100_0000, 0);
    chk("rstpost_result", result, 32'h3F0A_5147, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cosine_iterator.md
COSINE_ITERATOR -- requirements
Module: cosine_iterator

Interface
REQ-001 Parameter WIDTH, default 24, SHALL set the fractional bits of internal fixed point; datapath words are WIDTH+2 bits signed.
REQ-002 Parameter ITERATIONS, default 24, legal 1..31, SHALL set the number of CORDIC micro-rotations.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request strobe.
- in_ready  out  1  high when idle and able to accept.
- angle  in  32  IEEE-754 single, radians.
- out_valid  out  1  one-cycle pulse when result is valid.
- result  out  32  IEEE-754 single, cos(angle).
- theta  out  WIDTH+2  angle as signed fixed point, WIDTH fractional bits.
- x_s  out  32 x (WIDTH+2)  per-iteration x (cosine) values.
- w_s  out  32 x (WIDTH+2)  per-iteration residual angle z.

Function
REQ-004 An input SHALL be accepted on a rising clk edge with in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-005 Accept cycle: angle SHALL be converted to theta (truncate toward zero) and registered; ±0 and denormals SHALL give theta=0.
REQ-006 |angle| > 1.0, Inf or NaN: theta SHALL saturate to ±2^WIDTH (sign of angle; NaN gives +).
REQ-007 Initial state: x0 = K = 0x09B74EE (0.6072529 * 2^24), y0 = 0, z0 = theta.
REQ-008 Iteration i (0..ITERATIONS-1), one per clock: d=+1 if z>=0 else -1; x -= d*(y>>>i); y += d*(x>>>i); z -= d*ATAN[i]. All updates SHALL use the pre-iteration values, with arithmetic shifts and two's-complement wrap in WIDTH+2 bits.
REQ-009 ATAN[i] SHALL be round(atan(2^-i)*2^WIDTH); ATAN[0] = 0xC90FDB.
REQ-010 After the final iteration, x SHALL be converted to float in one cycle:
- Sign from the MSB; operate on the magnitude.
- Leading-one normalise; exponent = 127 + (leading-one position - WIDTH).
- Mantissa truncated to 23 bits.
- x=0 gives 0x00000000.
REQ-011 Latency: out_valid SHALL pulse exactly ITERATIONS+2 cycles after the accept edge. result SHALL hold until the next out_valid.
REQ-012 in_ready SHALL drop on the accept edge and rise in the cycle out_valid pulses; back-to-back accepts SHALL therefore be ITERATIONS+2 cycles apart.
REQ-013 Debug outputs:
- x_s[0]=K and w_s[0]=theta.
- x_s[i] and w_s[i] SHALL equal x and z after i iterations, for i=1..ITERATIONS.
- Entries above ITERATIONS SHALL read 0.
- All entries SHALL hold until the next accept.
REQ-014 For |angle| <= 1.0, result SHALL be within 16 ulp of the true cosine (WIDTH=24, ITERATIONS=24).

Reset
REQ-015 While rst=1, all state SHALL clear immediately, regardless of clk:
- in_ready=1, out_valid=0.
- result=0, theta=0.
- All x_s and w_s entries 0.
REQ-016 Reset asserted mid-computation SHALL abort that computation with no out_valid pulse. The first edge after rst deasserts SHALL be able to accept.

Structure
REQ-017 A shared package cordic_pkg SHALL hold WIDTH defaults, the K constant, the ATAN table and the IEEE field widths and bias.
REQ-018 Float-to-fixed and fixed-to-float conversion SHALL be combinational functions in the package. One sub-module, cordic_stage, SHALL implement a single micro-rotation, with the shift amount as an input.
REQ-019 Control SHALL be a 3-state FSM driven by an iteration counter:
- IDLE -> ITER on accept.
- ITER -> CONV after ITERATIONS cycles.
- CONV -> IDLE, pulsing out_valid.

Verification
REQ-020 Angle 0x00000000 -> theta 0x0000000, result within 16 ulp of 0x3F800000, out_valid exactly 26 cycles after accept.
REQ-021 Angle 0x3F800000 (1.0) -> theta 0x1000000, result within 16 ulp of 0x3F0A5147.
REQ-022 Angle 0xBF000000 (-0.5) -> theta 0x3800000, w_s[1]=theta+ATAN[0], result within 16 ulp of 0x3F60A940.
REQ-023 Angle 0x40000000 (2.0) -> theta saturated to 0x1000000, result identical to the 1.0 case.
REQ-024 in_valid held high through a busy period -> second accept occurs exactly 26 cycles after the first, and exactly one out_valid is seen per accept.
REQ-025 rst pulsed at iteration 10 -> outputs 0 and in_ready 1 during rst, no out_valid, and a new 1.0 request then completes correctly.
